// File: rtl/note_tone_player_if.sv
// Request channel between the music sequencer and the tone player:
// note handshake, abort, and end-of-note pulse.
interface note_tone_player_if #(
  parameter int unsigned DUR_W = 16
);
  logic             note_valid;
  logic             note_ready;
  logic [6:0]       note_idx;
  logic [DUR_W-1:0] note_dur;
  logic             stop;
  logic             done;

  modport master (
    output note_valid,
    output note_idx,
    output note_dur,
    output stop,
    input  note_ready,
    input  done
  );

  modport slave (
    input  note_valid,
    input  note_idx,
    input  note_dur,
    input  stop,
    output note_ready,
    output done
  );
endinterface

// File: rtl/note_tone_player.sv
// Plays one note at a time: fetches the phase increment from the frequency ROM,
// then runs a 20-bit phase accumulator whose MSB drives the buzzer for note_dur ticks.
module note_tone_player #(
  parameter int unsigned TICK_DIV = 8333,
  parameter int unsigned DUR_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  note_tone_player_if.slave req,
  output logic [6:0]        rom_addr,
  input  logic [19:0]       rom_dout,
  output logic              audio_out,
  output logic              busy
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StLoad, StPlay} state_e;

  state_e           state_q, state_d;
  logic [6:0]       addr_q, addr_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [19:0]      inc_q, inc_d;
  logic [19:0]      acc_q, acc_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             audio_q, audio_d;
  logic             done_q, done_d;
  logic             ready;
  logic             tick;

  // The done cycle is already IDLE but must not accept a new request.
  assign ready = (state_q == StIdle) && !done_q;
  assign tick  = (state_q == StPlay) && (presc_q == PrescMax);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dur_d   = dur_q;
    inc_d   = inc_q;
    acc_d   = acc_q;
    presc_d = presc_q;
    audio_d = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req.note_valid && ready) begin
          addr_d  = req.note_idx;
          dur_d   = req.note_dur;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (req.stop) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        inc_d   = rom_dout;
        acc_d   = '0;
        presc_d = '0;
        if (req.stop || (dur_q == '0)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        audio_d = acc_q[19];
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          acc_d = acc_q + inc_q;
          dur_d = dur_q - DUR_W'(1);
        end
        // Abort and the final tick end the note identically: one done pulse.
        if (req.stop || (tick && (dur_q == DUR_W'(1)))) begin
          state_d = StIdle;
          done_d  = 1'b1;
          audio_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      dur_q   <= '0;
      inc_q   <= '0;
      acc_q   <= '0;
      presc_q <= '0;
      audio_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dur_q   <= dur_d;
      inc_q   <= inc_d;
      acc_q   <= acc_d;
      presc_q <= presc_d;
      audio_q <= audio_d;
      done_q  <= done_d;
    end
  end

  assign req.note_ready = ready;
  assign req.done       = done_q;
  assign rom_addr       = addr_q;
  assign audio_out      = audio_q;
  assign busy           = (state_q != StIdle);

endmodule
